// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM: states, opcode classes,
// opcode/funct values and the datapath select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IF         = 4'd0,
        S_ID         = 4'd1,
        S_EX_R       = 4'd2,
        S_EX_I       = 4'd3,
        S_EX_MEMADDR = 4'd4,
        S_EX_BR      = 4'd5,
        S_EX_J       = 4'd6,
        S_MEM_LD     = 4'd7,
        S_MEM_ST     = 4'd8,
        S_WB_R       = 4'd9,
        S_WB_I       = 4'd10,
        S_WB_LD      = 4'd11,
        S_HALT       = 4'd12
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_IMM, C_MEM_LD, C_MEM_ST, C_BR_EQ, C_BR_NE, C_JUMP, C_HALT, C_ILLEGAL
    } opclass_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_SLTI  = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_IMMSH = 2'd3;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;

endpackage

// File: rtl/mc_opclass_decode.sv
// Combinational opcode classifier plus the ALU operation for I-type ALU instructions.
module mc_opclass_decode
    import mc_pkg::*;
#(
    parameter logic [5:0] OP_HALT = 6'b111111
) (
    input  logic [5:0] opcode,
    output opclass_t   opclass,
    output logic [2:0] imm_aluop
);

    always_comb begin
        opclass   = C_ILLEGAL;
        imm_aluop = ALU_ADD;
        case (opcode)
            OPC_RTYPE: opclass = C_R;
            OPC_ADDI:  opclass = C_IMM;
            OPC_ANDI:  begin opclass = C_IMM; imm_aluop = ALU_AND; end
            OPC_ORI:   begin opclass = C_IMM; imm_aluop = ALU_OR;  end
            OPC_SLTI:  begin opclass = C_IMM; imm_aluop = ALU_SLT; end
            OPC_LW:    opclass = C_MEM_LD;
            OPC_SW:    opclass = C_MEM_ST;
            OPC_BEQ:   opclass = C_BR_EQ;
            OPC_BNE:   opclass = C_BR_NE;
            OPC_J:     opclass = C_JUMP;
            OP_HALT:   opclass = C_HALT;
            default:   opclass = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, stalling on the memory-ready handshake.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter logic [5:0] OP_HALT = 6'b111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       memread,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [2:0] aluop,
    output logic       illegal_op,
    output logic       halted,
    output logic [3:0] state
);

    state_t     state_r, state_nxt;
    opclass_t   opclass;
    logic [2:0] imm_aluop;
    logic       irw_c, pcw_c, mr_c, mw_c, rw_c, iord_c, rdst_c, mtr_c, srca_c, ill_c, halt_c;
    logic [1:0] srcb_c, pcs_c;
    logic [2:0] aluop_c;

    // funct is decoded by the ALU control, not here
    logic unused_funct;
    assign unused_funct = ^funct;

    mc_opclass_decode #(.OP_HALT(OP_HALT)) u_dec (
        .opcode    (opcode),
        .opclass   (opclass),
        .imm_aluop (imm_aluop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= S_IF;
        else        state_r <= state_nxt;
    end

    always_comb begin
        state_nxt = state_r;
        irw_c = 1'b0; pcw_c = 1'b0; mr_c = 1'b0; mw_c = 1'b0; rw_c = 1'b0;
        iord_c = 1'b0; rdst_c = 1'b0; mtr_c = 1'b0; srca_c = 1'b0;
        ill_c = 1'b0; halt_c = 1'b0;
        srcb_c = SRCB_B; pcs_c = PCS_ALU; aluop_c = ALU_ADD;
        case (state_r)
            S_IF: begin
                mr_c   = 1'b1;
                srcb_c = SRCB_FOUR;
                if (mem_ready) begin
                    irw_c = 1'b1; pcw_c = 1'b1; state_nxt = S_ID;
                end
            end
            S_ID: begin
                srcb_c = SRCB_IMMSH;
                case (opclass)
                    C_R:                state_nxt = S_EX_R;
                    C_IMM:              state_nxt = S_EX_I;
                    C_MEM_LD, C_MEM_ST: state_nxt = S_EX_MEMADDR;
                    C_BR_EQ, C_BR_NE:   state_nxt = S_EX_BR;
                    C_JUMP:             state_nxt = S_EX_J;
                    C_HALT:             state_nxt = S_HALT;
                    default: begin ill_c = 1'b1; state_nxt = S_IF; end
                endcase
            end
            S_EX_R: begin
                srca_c = 1'b1; aluop_c = ALU_FUNCT; state_nxt = S_WB_R;
            end
            S_EX_I: begin
                srca_c = 1'b1; srcb_c = SRCB_IMM; aluop_c = imm_aluop; state_nxt = S_WB_I;
            end
            S_EX_MEMADDR: begin
                srca_c = 1'b1; srcb_c = SRCB_IMM;
                state_nxt = (opclass == C_MEM_ST) ? S_MEM_ST : S_MEM_LD;
            end
            S_EX_BR: begin
                srca_c = 1'b1; aluop_c = ALU_SUB; pcs_c = PCS_ALUOUT;
                pcw_c = (opclass == C_BR_NE) ? ~zero : zero;
                state_nxt = S_IF;
            end
            S_EX_J: begin
                pcs_c = PCS_JUMP; pcw_c = 1'b1; state_nxt = S_IF;
            end
            S_MEM_LD: begin
                mr_c = 1'b1; iord_c = 1'b1;
                if (mem_ready) state_nxt = S_WB_LD;
            end
            S_MEM_ST: begin
                mw_c = 1'b1; iord_c = 1'b1;
                if (mem_ready) state_nxt = S_IF;
            end
            S_WB_R:  begin rw_c = 1'b1; rdst_c = 1'b1; state_nxt = S_IF; end
            S_WB_I:  begin rw_c = 1'b1; state_nxt = S_IF; end
            S_WB_LD: begin rw_c = 1'b1; mtr_c = 1'b1; state_nxt = S_IF; end
            S_HALT:  halt_c = 1'b1;
            default: state_nxt = S_IF;
        endcase
    end

    // Outputs are squelched combinationally while reset is held so a fetch never leaks out
    assign irwrite    = rst_n & irw_c;
    assign pcwrite    = rst_n & pcw_c;
    assign memread    = rst_n & mr_c;
    assign memwrite   = rst_n & mw_c;
    assign regwrite   = rst_n & rw_c;
    assign iord       = rst_n & iord_c;
    assign regdst     = rst_n & rdst_c;
    assign memtoreg   = rst_n & mtr_c;
    assign alusrca    = rst_n & srca_c;
    assign alusrcb    = rst_n ? srcb_c : 2'd0;
    assign pcsource   = rst_n ? pcs_c : 2'd0;
    assign aluop      = rst_n ? aluop_c : 3'd0;
    assign illegal_op = rst_n & ill_c;
    assign halted     = rst_n & halt_c;
    assign state      = rst_n ? state_r : 4'd0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: random instruction stream summarised per
// instruction by a monitor, plus directed reset/halt/illegal scenarios.
module tb_mc_control_fsm;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       irwrite, pcwrite, memread, memwrite, regwrite;
    logic       iord, regdst, memtoreg, alusrca, illegal_op, halted;
    logic [1:0] alusrcb, pcsource;
    logic [2:0] aluop;
    logic [3:0] state;

    mc_control_fsm #(.OP_HALT(6'b111111)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .irwrite(irwrite), .pcwrite(pcwrite), .memread(memread),
        .memwrite(memwrite), .regwrite(regwrite), .iord(iord), .regdst(regdst),
        .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop(aluop), .illegal_op(illegal_op), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Per-instruction summary: counts of strobe cycles and a few captured selects
    typedef struct {
        int cycles; int irw; int pcw; int mr; int mw; int rw;
        int rdst; int mtr; int ill; int pcs; int alu_imm; int alu_reg;
    } rec_t;

    rec_t expq[$];
    bit   mon_en = 1'b0;

    function automatic rec_t model(input logic [5:0] op, input logic z, input int ifs, input int ms);
        rec_t r;
        r = '{default: 0};
        r.irw = 1; r.pcw = 1; r.mr = ifs + 1; r.alu_imm = 7; r.alu_reg = 7;
        case (op)
            6'h00: begin r.cycles = ifs + 4; r.rw = 1; r.rdst = 1; r.alu_reg = 2; end
            6'h08: begin r.cycles = ifs + 4; r.rw = 1; r.alu_imm = 0; end
            6'h0C: begin r.cycles = ifs + 4; r.rw = 1; r.alu_imm = 3; end
            6'h0D: begin r.cycles = ifs + 4; r.rw = 1; r.alu_imm = 4; end
            6'h0A: begin r.cycles = ifs + 4; r.rw = 1; r.alu_imm = 5; end
            6'h23: begin
                r.cycles = ifs + 5 + ms; r.mr += ms + 1; r.rw = 1; r.mtr = 1; r.alu_imm = 0;
            end
            6'h2B: begin r.cycles = ifs + 4 + ms; r.mw = ms + 1; r.alu_imm = 0; end
            6'h04, 6'h05: begin
                r.cycles = ifs + 3; r.alu_reg = 1;
                if ((op == 6'h04) ? z : !z) begin r.pcw = 2; r.pcs = 1; end
            end
            6'h02: begin r.cycles = ifs + 3; r.pcw = 2; r.pcs = 2; end
            default: begin r.cycles = ifs + 2; r.ill = 1; end
        endcase
        return r;
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    endfunction

    // Monitor: an instruction starts on entry to IF and ends on the next entry to IF
    rec_t acc;
    bit   active = 1'b0;
    logic [3:0] prev_state = 4'd0;
    always begin
        @(negedge clk);
        #2;
        if (!mon_en) begin
            active = 1'b0;
        end else begin
            if (state == S_IF && (!active || prev_state != S_IF)) begin
                if (active) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_instr", 1, 0);
                    end else begin
                        rec_t e;
                        e = expq.pop_front();
                        chk("cycles", acc.cycles, e.cycles);
                        chk("irwrite_cnt", acc.irw, e.irw);
                        chk("pcwrite_cnt", acc.pcw, e.pcw);
                        chk("memread_cnt", acc.mr, e.mr);
                        chk("memwrite_cnt", acc.mw, e.mw);
                        chk("regwrite_cnt", acc.rw, e.rw);
                        chk("regdst_cnt", acc.rdst, e.rdst);
                        chk("memtoreg_cnt", acc.mtr, e.mtr);
                        chk("illegal_cnt", acc.ill, e.ill);
                        chk("pcsource_last", acc.pcs, e.pcs);
                        chk("aluop_imm", acc.alu_imm, e.alu_imm);
                        chk("aluop_reg", acc.alu_reg, e.alu_reg);
                    end
                end
                acc = '{default: 0};
                acc.alu_imm = 7; acc.alu_reg = 7;
                active = 1'b1;
            end
            acc.cycles++;
            acc.irw += int'(irwrite);
            if (pcwrite) begin acc.pcw++; acc.pcs = int'(pcsource); end
            acc.mr += int'(memread);
            acc.mw += int'(memwrite);
            if (regwrite) begin
                acc.rw++; acc.rdst += int'(regdst); acc.mtr += int'(memtoreg);
            end
            acc.ill += int'(illegal_op);
            if (alusrca && alusrcb == 2'd2) acc.alu_imm = int'(aluop);
            if (alusrca && alusrcb == 2'd0) acc.alu_reg = int'(aluop);
            prev_state = state;
        end
    end

    logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};

    initial begin
        logic [5:0] op;
        logic       z;
        int         ifs, ms, ic, mc, n;
        bit         found;
        logic [3:0] add_states [5];
        add_states = '{S_IF, S_ID, S_EX_R, S_WB_R, S_IF};

        #3;
        chk("rst_memread", int'(memread), 0);
        chk("rst_irwrite", int'(irwrite), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_illegal", int'(illegal_op), 0);
        chk("rst_state", int'(state), 0);

        // Directed add trace with zero-wait memory
        opcode = 6'h00; funct = FN_ADD; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("add_state", int'(state), int'(add_states[i]));
            chk("add_irwrite", int'(irwrite), (i == 0 || i == 4) ? 1 : 0);
            chk("add_regwrite", int'(regwrite), (i == 3) ? 1 : 0);
            chk("add_regdst", int'(regdst), (i == 3) ? 1 : 0);
            if (i == 4) mem_ready = 1'b0;
            @(negedge clk);
        end

        // Random instruction stream
        for (int k = 0; k < 40; k++) begin
            if (k == 3) op = 6'h3E;
            else if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (known_op(op)) op = 6'($urandom_range(0, 63));
            end else op = ops[$urandom_range(0, 9)];
            z   = 1'($urandom);
            ifs = $urandom_range(0, 2);
            ms  = $urandom_range(0, 3);
            if (k == 5) begin op = 6'h23; ifs = 2; ms = 3; end
            expq.push_back(model(op, z, ifs, ms));
            n = model(op, z, ifs, ms).cycles;
            ic = 0; mc = 0;
            for (int c = 0; c < n; c++) begin
                @(negedge clk);
                if (c == 0) begin
                    opcode = op; funct = 6'($urandom); zero = z; mon_en = 1'b1;
                end
                if (state == S_IF) begin
                    mem_ready = (ic == ifs); ic++;
                end else if (state == S_MEM_LD || state == S_MEM_ST) begin
                    mem_ready = (mc == ms); mc++;
                end else begin
                    mem_ready = 1'($urandom);
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        for (int t = 0; t < 10 && expq.size() != 0; t++) @(negedge clk);
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        mon_en = 1'b0;

        // HALT parks the FSM until reset
        @(negedge clk);
        opcode = 6'h3F; mem_ready = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge clk); #2;
            if (state == S_HALT) found = 1'b1;
        end
        chk("reach_halt", int'(found), 1);
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            mem_ready = 1'($urandom);
            #2;
            chk("halt_halted", int'(halted), 1);
            chk("halt_strobes", int'({irwrite, pcwrite, memread, memwrite, regwrite, illegal_op}), 0);
            chk("halt_state", int'(state), int'(S_HALT));
        end
        #1 rst_n = 1'b0;
        #1;
        chk("halt_rst_halted", int'(halted), 0);
        chk("halt_rst_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b0; opcode = 6'h2B;
        #2;
        chk("post_halt_state", int'(state), int'(S_IF));
        chk("post_halt_halted", int'(halted), 0);
        chk("post_halt_memread", int'(memread), 1);

        // sw stalled in MEM_ST, then asynchronous reset mid-access
        found = 1'b0;
        for (int t = 0; t < 10 && !found; t++) begin
            @(negedge clk);
            mem_ready = (state != S_MEM_ST);
            #2;
            if (state == S_MEM_ST) found = 1'b1;
        end
        chk("reach_mem_st", int'(found), 1);
        chk("st_memwrite", int'(memwrite), 1);
        chk("st_iord", int'(iord), 1);
        #1 rst_n = 1'b0;
        #0.5;
        chk("st_rst_memwrite", int'(memwrite), 0);
        chk("st_rst_iord", int'(iord), 0);
        chk("st_rst_regwrite", int'(regwrite), 0);
        chk("st_rst_state", int'(state), 0);
        @(negedge clk);
        rst_n = 1'b1; mem_ready = 1'b1;
        #2;
        chk("st_post_state", int'(state), int'(S_IF));
        chk("st_post_irwrite", int'(irwrite), 1);
        chk("st_post_memwrite", int'(memwrite), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
